// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte stream -> header parse -> imem/dmem write ports -> cpu_enable
module program_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic [63:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IMEM, S_DMEM, S_FLUSH, S_RUN, S_ERR
  } state_t;

  localparam logic [15:0] IMEM_MAX = 16'(IMEM_WORDS);
  localparam logic [15:0] DMEM_MAX = 16'(DMEM_WORDS);

  state_t      state, next_state;
  logic [2:0]  byte_cnt;
  logic [15:0] idx;
  logic [15:0] n_i;
  logic [15:0] n_d;
  logic [55:0] acc;

  logic        fire;
  logic        word_done;
  logic [31:0] word32;
  logic        last_imem;
  logic        last_dmem;

  assign fire      = s_valid & s_ready;
  assign word_done = (state == S_DMEM) ? (byte_cnt == 3'd7) : (byte_cnt == 3'd3);
  // Completed 4-byte word: the header during HDR, an instruction during IMEM.
  assign word32    = {s_data, acc[23:0]};
  assign last_imem = (idx == n_i - 16'd1);
  assign last_dmem = (idx == n_d - 16'd1);

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (start) next_state = S_HDR;
      S_HDR: begin
        if (fire && word_done) begin
          if (word32[15:0] > IMEM_MAX || word32[31:16] > DMEM_MAX) next_state = S_ERR;
          else if (word32[15:0] != 16'd0)                           next_state = S_IMEM;
          else if (word32[31:16] != 16'd0)                          next_state = S_DMEM;
          else                                                      next_state = S_RUN;
        end
      end
      S_IMEM: if (fire && word_done && last_imem) next_state = (n_d != 16'd0) ? S_DMEM : S_FLUSH;
      S_DMEM: if (fire && word_done && last_dmem) next_state = S_FLUSH;
      S_FLUSH: next_state = S_RUN;
      S_RUN:   if (start) next_state = S_HDR;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= S_IDLE;
      byte_cnt   <= 3'd0;
      idx        <= 16'd0;
      n_i        <= 16'd0;
      n_d        <= 16'd0;
      acc        <= 56'd0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      cpu_enable <= 1'b0;
      error      <= 1'b0;
      imem_wen   <= 1'b0;
      imem_addr  <= 64'd0;
      imem_wdata <= 32'd0;
      dmem_wen   <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
    end else begin
      state      <= next_state;
      imem_wen   <= 1'b0;
      dmem_wen   <= 1'b0;
      // Status flags are decoded from the next state so they line up with it.
      s_ready    <= (next_state == S_HDR) || (next_state == S_IMEM) || (next_state == S_DMEM);
      busy       <= (next_state == S_HDR) || (next_state == S_IMEM) ||
                    (next_state == S_DMEM) || (next_state == S_FLUSH);
      cpu_enable <= (next_state == S_RUN);
      error      <= (next_state == S_ERR);

      if (next_state == S_HDR && state != S_HDR) begin
        byte_cnt <= 3'd0;
        idx      <= 16'd0;
        acc      <= 56'd0;
      end else if (fire) begin
        if (word_done) begin
          byte_cnt <= 3'd0;
          acc      <= 56'd0;
          unique case (state)
            S_HDR: begin
              n_i <= word32[15:0];
              n_d <= word32[31:16];
            end
            S_IMEM: begin
              imem_wen   <= 1'b1;
              imem_addr  <= {46'd0, idx, 2'b00};
              imem_wdata <= word32;
              idx        <= last_imem ? 16'd0 : idx + 16'd1;
            end
            S_DMEM: begin
              dmem_wen   <= 1'b1;
              dmem_addr  <= {45'd0, idx, 3'b000};
              dmem_wdata <= {s_data, acc};
              idx        <= idx + 16'd1;
            end
            default: ;
          endcase
        end else begin
          acc[{byte_cnt, 3'b000} +: 8] <= s_data;
          byte_cnt                     <= byte_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  program_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
    .clk(clk), .arst(arst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );

  typedef struct {
    bit          is_d;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input bit d, input logic [63:0] addr, input logic [63:0] data);
    wr_t e;
    e.is_d = d;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon_write(input bit d, input logic [63:0] addr, input logic [63:0] data);
    wr_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write: got dmem=%0d addr=%0h data=%0h expected none at %0t",
               d, addr, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("wr_port", {63'd0, d}, {63'd0, e.is_d});
      check("wr_addr", addr, e.addr);
      check("wr_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (arst !== 1'b1) begin
      if (imem_wen && dmem_wen) check("both_wen", 64'd1, 64'd0);
      if (imem_wen) mon_write(1'b0, imem_addr, {32'd0, imem_wdata});
      if (dmem_wen) mon_write(1'b1, dmem_addr, dmem_wdata);
    end
  end

  task automatic send_one();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got s_ready=0 for 200 cycles expected 1");
    end
  endtask

  task automatic send_stim(input bit gapped);
    while (stim.size() > 0) begin
      if (gapped) begin
        int g;
        g = 0;
        while ($urandom_range(0, 1) == 1 && g < 8) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
          g++;
        end
      end
      s_data  = stim.pop_front();
      s_valid = 1'b1;
      send_one();
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_basic(input bit gapped);
    expect_wr(1'b0, 64'd0, 64'h0000_0000_0000_0013);
    expect_wr(1'b0, 64'd4, 64'h0000_0000_0010_0093);
    expect_wr(1'b1, 64'd0, 64'h0807_0605_0403_0201);
    stim = '{8'h02, 8'h00, 8'h01, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00,
             8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_stim(gapped);
    @(negedge clk);
    check("flush_enable", {63'd0, cpu_enable}, 64'd0);
    check("flush_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("run_enable", {63'd0, cpu_enable}, 64'd1);
    check("run_busy", {63'd0, busy}, 64'd0);
    #1;
    check("basic_all_written", exp_q.size(), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst    = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #2;
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_enable", {63'd0, cpu_enable}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_imem_wen", {63'd0, imem_wen}, 64'd0);
    check("rst_dmem_wen", {63'd0, dmem_wen}, 64'd0);
    check("rst_dmem_wdata", dmem_wdata, 64'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // No start: stream bytes must not be consumed.
    s_valid = 1'b1;
    s_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_s_ready", {63'd0, s_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    pulse_start();
    @(negedge clk);
    check("hdr_s_ready", {63'd0, s_ready}, 64'd1);
    check("hdr_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    load_basic(1'b0);

    // Restart from RUN with a gapped stream.
    pulse_start();
    @(negedge clk);
    check("restart_enable_drop", {63'd0, cpu_enable}, 64'd0);
    @(posedge clk);
    #1;
    load_basic(1'b1);

    // Zero-count header.
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stim(1'b0);
    @(negedge clk);
    check("zero_enable", {63'd0, cpu_enable}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;

    // Oversize header: N_I = 513.
    pulse_start();
    stim = '{8'h01, 8'h02, 8'h00, 8'h00};
    send_stim(1'b0);
    @(negedge clk);
    check("ovr_error", {63'd0, error}, 64'd1);
    check("ovr_s_ready", {63'd0, s_ready}, 64'd0);
    check("ovr_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    pulse_start();
    s_valid = 1'b1;
    s_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_s_ready", {63'd0, s_ready}, 64'd0);
      check("err_sticky", {63'd0, error}, 64'd1);
      check("err_enable", {63'd0, cpu_enable}, 64'd0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    arst = 1'b1;
    #1;
    check("err_rst_error", {63'd0, error}, 64'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // Reset after 6 instruction bytes: only word 0 is written.
    pulse_start();
    expect_wr(1'b0, 64'd0, 64'h0000_0000_0000_0013);
    stim = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_stim(1'b0);
    #2;
    arst = 1'b1;
    #1;
    check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_imem_addr", imem_addr, 64'd0);
    check("mid_rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
    check("mid_rst_written", exp_q.size(), 64'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    @(negedge clk);
    check("mid_rst_idle_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    pulse_start();
    load_basic(1'b0);

    // Restart from RUN with a single instruction word.
    pulse_start();
    @(negedge clk);
    check("restart2_enable_drop", {63'd0, cpu_enable}, 64'd0);
    @(posedge clk);
    #1;
    expect_wr(1'b0, 64'd0, 64'h0000_0000_0000_0033);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00};
    send_stim(1'b0);
    @(negedge clk);
    check("ni1_flush_enable", {63'd0, cpu_enable}, 64'd0);
    @(negedge clk);
    check("ni1_run_enable", {63'd0, cpu_enable}, 64'd1);
    check("ni1_run_busy", {63'd0, busy}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("final_all_written", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
